// File: rtl/data_mem_resp_pkg.sv
// Shared constants and helpers for the data memory response block.
// The request/reset polarity names mirror the processor-wide definitions.
package data_mem_resp_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          LANES       = 4;

    // Only aligned byte, halfword, three-byte and word lane patterns are accepted.
    function automatic logic sel_legal(input logic [LANES-1:0] sel);
        case (sel)
            4'b1111, 4'b1100, 4'b0011,
            4'b1000, 4'b0100, 4'b0010, 4'b0001,
            4'b0111, 4'b1110: sel_legal = 1'b1;
            default:          sel_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the load/store unit (master) and the
// data memory (slave).
interface data_mem_resp_if;
    import data_mem_resp_pkg::*;

    logic             ce_i;
    logic             we_i;
    logic [31:0]      addr_i;
    logic [LANES-1:0] sel_i;
    logic [31:0]      data_i;
    logic [31:0]      data_o;
    logic             stallreq_o;
    logic             err_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stallreq_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stallreq_o, err_o
    );

endinterface

// File: rtl/data_mem_resp_byte_lane_ram.sv
// One byte lane of data storage: synchronous write, registered read.
// Only the read register is reset; array contents survive reset.
module byte_lane_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with zero-wait stores and one-stall-cycle loads, built from
// four byte lanes; lane 3 holds bits 31:24 (big-endian byte offset 0).
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_resp_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  in_reset;
    logic                  req_err;
    logic                  store_ok;
    logic                  load_ok;
    logic                  load_accept;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           rd_word;
    logic                  addr_unused;

    assign in_reset    = (rst == RstEnable);
    assign word_idx    = bus.addr_i[ADDR_WIDTH+1:2];
    assign addr_unused = ^bus.addr_i[1:0];

    // Any upper address bit set is rejected rather than wrapped onto a valid word.
    assign req_err  = !in_reset && (bus.ce_i == ChipEnable) &&
                      (!sel_legal(bus.sel_i) || (bus.addr_i[31:ADDR_WIDTH+2] != '0));
    assign store_ok = !in_reset && (bus.ce_i == ChipEnable) &&
                      (bus.we_i == WriteEnable) && !req_err;
    assign load_ok  = !in_reset && (bus.ce_i == ChipEnable) &&
                      (bus.we_i != WriteEnable) && !req_err;

    always_ff @(posedge clk) begin
        if (in_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Loads are only accepted from IDLE; dropping ce_i during the stall cycle
    // removes load_ok, so the FSM stays in IDLE and nothing is captured.
    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        load_accept = 1'b0;
        case (state)
            IDLE: begin
                if (load_ok) begin
                    stall       = 1'b1;
                    load_accept = 1'b1;
                    state_next  = RD_WAIT;
                end
            end
            RD_WAIT: state_next = RD_DONE;
            RD_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
        byte_lane_ram #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk   (clk),
            .rst   (in_reset),
            .we    (store_ok && bus.sel_i[lane]),
            .re    (load_accept),
            .addr  (word_idx),
            .wdata (bus.data_i[8*lane +: 8]),
            .rdata (rd_word[8*lane +: 8])
        );
    end

    assign bus.data_o     = (!in_reset && !req_err && (state != IDLE)) ? rd_word : ZeroWord;
    assign bus.stallreq_o = stall;
    assign bus.err_o      = req_err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised scoreboard bench for data_mem_resp: stimulus pushes expected load
// words, a negedge monitor pops them when a stall cycle ends.
module tb_data_mem_resp;

    localparam int AW     = 10;
    localparam int NWORDS = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    data_mem_resp_if bus ();

    data_mem_resp #(
        .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          block  = 0;
    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [31:0] exp_q [$];

    logic        mon_prev_stall;
    logic        mon_hold_pending;
    logic [31:0] mon_hold_val;
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a, input logic [3:0] s);
        logic legal;
        legal = s inside {4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100,
                          4'b0010, 4'b0001, 4'b0111, 4'b1110};
        return !legal || ((a >> (AW + 2)) != 32'd0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    task automatic drive(input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        bus.ce_i   = ce;
        bus.we_i   = we;
        bus.addr_i = a;
        bus.sel_i  = s;
        bus.data_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle();
        block = 0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic e;
        int   w;
        e = model_err(a, s);
        if (block != 0 && e) do_idle();
        block = 0;
        drive(1'b1, 1'b1, a, s, d);
        @(negedge clk);
        check_bit("st_err", bus.err_o, e);
        check_bit("st_stall", bus.stallreq_o, 1'b0);
        if (!e) begin
            w = word_of(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
        end
        next_cycle();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] s);
        logic e;
        e = model_err(a, s);
        if (block != 0) begin
            if (e) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            else   drive(1'b1, 1'b0, a, s, $urandom);
            @(negedge clk);
            if (!e) check_bit("ld_in_done_nostall", bus.stallreq_o, 1'b0);
            next_cycle();
            block = 0;
        end
        drive(1'b1, 1'b0, a, s, $urandom);
        @(negedge clk);
        check_bit("ld_err", bus.err_o, e);
        check_bit("ld_stall", bus.stallreq_o, !e);
        check("ld_idle_data", bus.data_o, 32'h0);
        if (e) begin
            next_cycle();
        end else begin
            exp_q.push_back(model_mem[word_of(a)]);
            next_cycle();
            next_cycle();
            block = 1;
        end
    endtask

    function automatic logic [3:0] pick_sel();
        if ($urandom_range(0, 5) == 0) return 4'($urandom_range(0, 15));
        case ($urandom_range(0, 8))
            0: return 4'b1111;
            1: return 4'b1100;
            2: return 4'b0011;
            3: return 4'b1000;
            4: return 4'b0100;
            5: return 4'b0010;
            6: return 4'b0001;
            7: return 4'b0111;
            default: return 4'b1110;
        endcase
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        a = {24'h0, 6'($urandom_range(0, NWORDS - 1)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
        return a;
    endfunction

    // Monitor: the cycle after a stall must show the load word, and the one after that must repeat it.
    initial begin
        mon_prev_stall   = 1'b0;
        mon_hold_pending = 1'b0;
        mon_hold_val     = 32'h0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                mon_prev_stall   = 1'b0;
                mon_hold_pending = 1'b0;
            end else begin
                if (mon_prev_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: data %h with no load outstanding at %0t",
                                 bus.data_o, $time);
                        mon_hold_pending = 1'b0;
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("ld_data", bus.data_o, mon_exp);
                        mon_hold_val     = mon_exp;
                        mon_hold_pending = 1'b1;
                    end
                end else if (mon_hold_pending) begin
                    check("ld_hold", bus.data_o, mon_hold_val);
                    mon_hold_pending = 1'b0;
                end
                mon_prev_stall = bus.stallreq_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hFFFF_0001, 4'b1010, 32'h0);
        repeat (2) next_cycle();
        @(negedge clk);
        check_bit("rst_err", bus.err_o, 1'b0);
        check_bit("rst_stall", bus.stallreq_o, 1'b0);
        check("rst_data", bus.data_o, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0);
        @(negedge clk);
        check_bit("rst_load_nostall", bus.stallreq_o, 1'b0);
        next_cycle();
        rst = 1'b0;
        do_idle();

        for (int i = 0; i < NWORDS; i++) do_store(32'(i * 4), 4'b1111, $urandom);

        // Word store then load, byte merge, illegal requests leave storage alone.
        do_store(32'h10, 4'b1111, 32'hDEADBEEF);
        do_load(32'h10, 4'b1111);
        do_store(32'h11, 4'b0100, 32'h55555555);
        do_load(32'h10, 4'b1111);
        do_load(32'h10, 4'b1010);
        do_load(32'h0001_0000, 4'b1111);
        do_store(32'h10, 4'b1010, 32'h0);
        do_store(32'h0001_0010, 4'b1111, 32'h0);
        do_load(32'h10, 4'b1111);

        // Back-to-back loads, the second arriving while the first is finishing.
        do_load(32'h10, 4'b1111);
        do_load(32'h14, 4'b1111);
        do_idle();

        // Flush: ce_i drops inside the stall cycle.
        drive(1'b1, 1'b0, 32'h14, 4'b1111, 32'h0);
        @(negedge clk);
        check_bit("flush_stall", bus.stallreq_o, 1'b1);
        #1 bus.ce_i = 1'b0;
        #1 check_bit("flush_stall_drop", bus.stallreq_o, 1'b0);
        exp_q.push_back(32'h0);
        next_cycle();
        do_load(32'h14, 4'b1111);
        do_idle();

        // Reset during RD_WAIT aborts the load and blocks a concurrent store.
        drive(1'b1, 1'b0, 32'h10, 4'b1111, 32'h0);
        @(negedge clk);
        check_bit("rstab_stall", bus.stallreq_o, 1'b1);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h10, 4'b1111, 32'h12345678);
        @(negedge clk);
        check("rstab_data_in_rst", bus.data_o, 32'h0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check_bit("rstab_idle_stall", bus.stallreq_o, 1'b0);
        check("rstab_idle_data", bus.data_o, 32'h0);
        next_cycle();
        block = 0;
        do_load(32'h10, 4'b1111);

        // Load directly after a store to the same word.
        do_store(32'h20, 4'b1111, 32'hCAFEF00D);
        do_load(32'h20, 4'b1111);
        do_store(32'h22, 4'b0011, 32'h77777777);
        do_load(32'h21, 4'b0100);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: do_store(pick_addr(), pick_sel(), $urandom);
                9:          do_idle();
                default:    do_load(pick_addr(), pick_sel());
            endcase
        end

        repeat (4) do_idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high (`RstEnable).
REQ-004 SHALL have port ce_i, input, 1, request valid (`ChipEnable).
REQ-005 SHALL have port we_i, input, 1, 1 = store, 0 = load (`WriteEnable).
REQ-006 SHALL have port addr_i, input, 32, byte address; word index = addr_i[ADDR_WIDTH+1:2].
REQ-007 SHALL have port sel_i, input, 4, byte-lane enables; sel_i[3] = bits 31:24 = byte offset 0 (big-endian).
REQ-008 SHALL have port data_i, input, 32, store data, pre-replicated per lane by the requester.
REQ-009 SHALL have port data_o, output, 32, load data, full word.
REQ-010 SHALL have port stallreq_o, output, 1, pipeline hold request while a load is outstanding.
REQ-011 SHALL have port err_o, output, 1, illegal request flag, combinational, valid only while ce_i = 1.

Function
REQ-012 Legal sel_i SHALL be exactly 1111, 1100, 0011, 1000, 0100, 0010, 0001, 0111, 1110.
REQ-013 err_o SHALL be 1 when ce_i = 1 and (sel_i is illegal or addr_i[31:ADDR_WIDTH+2] != 0); otherwise 0.
REQ-014 Erroneous requests SHALL NOT write storage or stall; data_o SHALL be `ZeroWord for them.
REQ-015 Store (ce_i=1, we_i=1, no error) SHALL write only lanes with sel_i bit set, at the same rising edge, zero stall, from any state.
REQ-016 FSM states SHALL be IDLE, RD_WAIT, RD_DONE.
REQ-017 IDLE: load with no error SHALL assert stallreq_o combinationally, register the addressed word, and go to RD_WAIT.
REQ-018 RD_WAIT: stallreq_o SHALL be 0, data_o SHALL present the registered word, next state RD_DONE.
REQ-019 RD_DONE: data_o SHALL still present the registered word, stallreq_o = 0, next state IDLE unconditionally.
REQ-020 Load latency SHALL be one stall cycle; the requester holds ce_i/addr_i/sel_i stable while stallreq_o = 1.
REQ-021 data_o SHALL be `ZeroWord in IDLE except during a same-cycle error-free load (then undefined-free: `ZeroWord until registered).
REQ-022 If ce_i drops while stallreq_o = 1 (flush), the FSM SHALL return to IDLE at the next edge with no data capture.
REQ-023 A load to a word written by a store in the immediately preceding cycle SHALL return the new data.
REQ-024 Back-to-back loads SHALL each incur one stall cycle; a load arriving in RD_DONE SHALL be accepted in the following IDLE cycle.
REQ-025 Word index wrap SHALL NOT occur; out-of-range addresses are errors per REQ-013.

Reset
REQ-026 With rst = 1 at a rising edge: state SHALL become IDLE, the read register SHALL be `ZeroWord.
REQ-027 While rst = 1: stallreq_o = 0, err_o = 0, data_o = `ZeroWord, and no store SHALL take effect.
REQ-028 Reset during RD_WAIT SHALL abort the load; storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 `RstEnable, `ChipEnable, `WriteEnable, `ZeroWord SHALL come from the shared defines.v; FSM state encodings SHALL be local.
REQ-030 Storage SHALL be one sub-module, byte_lane_ram (one byte lane, write enable, registered read), instantiated four times.

Verification
REQ-031 Reset, then SW addr 0x10 data 0xDEADBEEF sel 1111, then LW 0x10 -> stallreq_o=1 one cycle, next cycle data_o=0xDEADBEEF.
REQ-032 SB addr 0x11 data 0x55555555 sel 0100 over 0xDEADBEEF, LW 0x10 -> data_o=0xDE55BEEF.
REQ-033 LW with sel 1010 or addr 0x00010000 (ADDR_WIDTH=10) -> err_o=1, stallreq_o=0, storage unchanged.
REQ-034 LW started, rst=1 during RD_WAIT -> next cycle state IDLE, stallreq_o=0, data_o=0x00000000.
REQ-035 Two consecutive LW 0x10, 0x14 -> two separate one-cycle stalls, correct data for each.
REQ-036 LW with ce_i dropped during the stall cycle -> FSM back to IDLE next edge, data_o=0x00000000.
